// File: rtl/alu_muldiv.sv
// EX-stage ALU: registered single-cycle ops plus an iterative radix-2 mul/div
// unit that owns the architectural HI/LO pair, with a valid/ready issue port.
module alu_muldiv #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_AND   = 5'h02;
  localparam logic [4:0] OP_OR    = 5'h03;
  localparam logic [4:0] OP_XOR   = 5'h04;
  localparam logic [4:0] OP_SLT   = 5'h05;
  localparam logic [4:0] OP_SLL   = 5'h06;
  localparam logic [4:0] OP_SRL   = 5'h07;
  localparam logic [4:0] OP_SRA   = 5'h08;
  localparam logic [4:0] OP_LUI   = 5'h09;
  localparam logic [4:0] OP_NOR   = 5'h0A;
  localparam logic [4:0] OP_SLTU  = 5'h0B;
  localparam logic [4:0] OP_MULT  = 5'h10;
  localparam logic [4:0] OP_DIV   = 5'h12;
  localparam logic [4:0] OP_MFHI  = 5'h14;
  localparam logic [4:0] OP_MFLO  = 5'h15;
  localparam logic [4:0] OP_MTHI  = 5'h16;
  localparam logic [4:0] OP_MTLO  = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t               state_reg, state_next;
  logic [SHW-1:0]       cnt_reg, cnt_next;
  logic                 is_div_reg, is_div_next;
  logic                 neg_q_reg, neg_q_next;
  logic                 neg_r_reg, neg_r_next;
  logic                 div0_reg, div0_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic [WIDTH-1:0]     acc_reg, acc_next;
  logic [WIDTH-1:0]     low_reg, low_next;
  logic                 out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]     y_reg, y_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;

  logic                 accept;
  logic                 is_multi;
  logic                 is_signed;
  logic                 sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     alu_y;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign in_ready  = (state_reg == S_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign is_multi  = (op[4:2] == 3'b100);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = is_signed && a[WIDTH-1];
  assign sb        = is_signed && b[WIDTH-1];
  assign mag_a     = sa ? -a : a;
  assign mag_b     = sb ? -b : b;

  // Multiply: acc holds the running upper half, low shifts the multiplier out
  // and the product's lower half in.
  assign mul_sum   = {1'b0, acc_reg} + (low_reg[0] ? {1'b0, mcand_reg} : '0);

  // Restoring divide: acc is the partial remainder, low shifts the dividend out
  // and the quotient bits in. The subtraction fits WIDTH bits whenever div_ge.
  assign rem_shift = {acc_reg, low_reg[WIDTH-1]};
  assign div_ge    = (rem_shift >= {1'b0, mcand_reg});
  assign div_diff  = rem_shift[WIDTH-1:0] - mcand_reg;

  assign prod_fix  = neg_q_reg ? -{acc_reg, low_reg} : {acc_reg, low_reg};
  assign quo_fix   = neg_q_reg ? -low_reg : low_reg;
  assign rem_fix   = neg_r_reg ? -acc_reg : acc_reg;

  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:  alu_y = a + b;
      OP_SUB:  alu_y = a - b;
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_NOR:  alu_y = ~(a | b);
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  alu_y = b << a[SHW-1:0];
      OP_SRL:  alu_y = b >> a[SHW-1:0];
      OP_SRA:  alu_y = $unsigned($signed(b) >>> a[SHW-1:0]);
      OP_LUI:  alu_y = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: alu_y = hi_reg;
      OP_MFLO: alu_y = lo_reg;
      OP_MTHI: alu_y = a;
      OP_MTLO: alu_y = a;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    is_div_next    = is_div_reg;
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
    div0_next      = div0_reg;
    mcand_next     = mcand_reg;
    acc_next       = acc_reg;
    low_next       = low_reg;
    out_valid_next = 1'b0;
    y_next         = y_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (is_multi) begin
            is_div_next = op[1];
            neg_q_next  = sa ^ sb;
            neg_r_next  = sa;
            div0_next   = (b == '0);
            mcand_next  = op[1] ? mag_b : mag_a;
            low_next    = op[1] ? mag_a : mag_b;
            acc_next    = '0;
            cnt_next    = '0;
            state_next  = S_BUSY;
          end else begin
            y_next         = alu_y;
            out_valid_next = 1'b1;
            if (op == OP_MTHI) hi_next = a;
            if (op == OP_MTLO) lo_next = a;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_next = S_IDLE;
        end else begin
          if (is_div_reg) begin
            acc_next = div_ge ? div_diff : rem_shift[WIDTH-1:0];
            low_next = {low_reg[WIDTH-2:0], div_ge};
          end else begin
            acc_next = mul_sum[WIDTH:1];
            low_next = {mul_sum[0], low_reg[WIDTH-1:1]};
          end
          cnt_next = cnt_reg + SHW'(1);
          if (cnt_reg == SHW'(WIDTH-1)) state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
        if (!flush) begin
          out_valid_next = 1'b1;
          if (is_div_reg) begin
            // Divide by zero leaves the dividend in HI and saturates the quotient.
            lo_next = div0_reg ? '1 : quo_fix;
            hi_next = rem_fix;
            y_next  = div0_reg ? '1 : quo_fix;
          end else begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
            y_next  = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      is_div_reg    <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      div0_reg      <= 1'b0;
      mcand_reg     <= '0;
      acc_reg       <= '0;
      low_reg       <= '0;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      is_div_reg    <= is_div_next;
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
      div0_reg      <= div0_next;
      mcand_reg     <= mcand_next;
      acc_reg       <= acc_next;
      low_reg       <= low_next;
      out_valid_reg <= out_valid_next;
      y_reg         <= y_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign y         = y_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases plus randomized ops
// compared against an arithmetic reference model of the op set and HI/LO.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic [4:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] y, hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .y(y), .hi(hi), .lo(lo)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: single-cycle results from plain integer arithmetic.
  function automatic logic [W-1:0] ref_single(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    int unsigned sh;
    longint sbv, pw;
    logic [63:0] t;
    sh  = av % W;
    sbv = longint'($signed(bv));
    pw  = longint'(1) << sh;
    case (o)
      5'h00: return av + bv;
      5'h01: return av - bv;
      5'h02: return av & bv;
      5'h03: return av | bv;
      5'h04: return av ^ bv;
      5'h0A: return ~(av | bv);
      5'h05: return (longint'($signed(av)) < sbv) ? 1 : 0;
      5'h0B: return (av < bv) ? 1 : 0;
      5'h06: begin t = {32'b0, bv} * 64'(pw); return t[W-1:0]; end
      5'h07: return 32'(longint'({32'b0, bv}) / pw);
      5'h08: begin
        if (sbv >= 0) return 32'(sbv / pw);
        return 32'(-((-sbv + pw - 1) / pw));
      end
      5'h09: return bv * 32'd65536;
      5'h14: return m_hi;
      5'h15: return m_lo;
      5'h16: return av;
      5'h17: return av;
      default: return '0;
    endcase
  endfunction

  task automatic ref_muldiv(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                            output logic [W-1:0] ehi, output logic [W-1:0] elo);
    logic [63:0] p;
    longint q, r;
    p = '0;
    q = 0;
    r = 0;
    if (o == 5'h10) p = longint'($signed(av)) * longint'($signed(bv));
    if (o == 5'h11) p = {32'b0, av} * {32'b0, bv};
    if (o == 5'h12) begin
      q = (bv == 0) ? 0 : longint'($signed(av)) / longint'($signed(bv));
      r = (bv == 0) ? 0 : longint'($signed(av)) % longint'($signed(bv));
    end
    if (o == 5'h13) begin
      q = (bv == 0) ? 0 : longint'({32'b0, av}) / longint'({32'b0, bv});
      r = (bv == 0) ? 0 : longint'({32'b0, av}) % longint'({32'b0, bv});
    end
    if (o[1]) p = {r[31:0], q[31:0]};
    if (o[1] && bv == 0) p = {av, 32'hFFFF_FFFF};
    ehi = p[63:32];
    elo = p[31:0];
  endtask

  task automatic run_single(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] ey);
    check_eq("sc_ready", in_ready, 1);
    op = o; a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (o == 5'h16) m_hi = av;
    if (o == 5'h17) m_lo = av;
    check_eq("sc_valid", out_valid, 1);
    check_eq("sc_y", y, ey);
    check_eq("sc_hi", hi, m_hi);
    check_eq("sc_lo", lo, m_lo);
    $display("[%0t] single op=%h a=%h b=%h y=%h hi=%h lo=%h", $time, o, av, bv, y, hi, lo);
  endtask

  task automatic run_multi(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int lat, rdy_busy;
    check_eq("mc_ready", in_ready, 1);
    op = o; a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    rdy_busy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy++;
      tick();
      lat++;
    end
    check_eq("mc_latency", lat, W + 2);
    check_eq("mc_ready_busy", rdy_busy, 0);
    check_eq("mc_ready_done", in_ready, 1);
    check_eq("mc_hi", hi, ehi);
    check_eq("mc_lo", lo, elo);
    check_eq("mc_y", y, elo);
    m_hi = ehi;
    m_lo = elo;
    $display("[%0t] multi op=%h a=%h b=%h lat=%0d hi=%h lo=%h", $time, o, av, bv, lat, hi, lo);
  endtask

  initial begin
    logic [4:0]   o;
    logic [W-1:0] av, bv, ehi, elo;
    int seen, lat;

    repeat (3) tick();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Directed single-cycle vectors with a=4, b=0x8000_00F0.
    run_single(5'h00, 32'h4, 32'h8000_00F0, 32'h8000_00F4);
    run_single(5'h08, 32'h4, 32'h8000_00F0, 32'hF800_000F);
    run_single(5'h05, 32'h4, 32'h8000_00F0, 32'h0000_0000);
    run_single(5'h0B, 32'h4, 32'h8000_00F0, 32'h0000_0001);
    run_single(5'h09, 32'h4, 32'h8000_00F0, 32'h00F0_0000);
    run_single(5'h0A, 32'h4, 32'h8000_00F0, 32'h7FFF_FF0B);
    run_single(5'h06, 32'h4, 32'h8000_00F0, 32'h0000_0F00);
    run_single(5'h07, 32'h4, 32'h8000_00F0, 32'h0800_000F);
    run_single(5'h1F, 32'h4, 32'h8000_00F0, 32'h0000_0000);

    // Directed mul/div corners.
    run_multi(5'h10, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_multi(5'h12, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_multi(5'h13, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, 32'h7FFF_FFFC);
    run_multi(5'h13, 32'h5, 32'h0, 32'h0000_0005, 32'hFFFF_FFFF);
    run_multi(5'h12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_multi(5'h12, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Flush mid-BUSY keeps HI/LO and produces no result.
    run_single(5'h16, 32'h1234, 32'h0, 32'h1234);
    op = 5'h11; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int k = 1; k < 10; k++) begin
      if (out_valid) seen++;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_ready", in_ready, 1);
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      tick();
    end
    check_eq("flush_no_valid", seen, 0);
    check_eq("flush_hi", hi, 32'h1234);
    check_eq("flush_lo", lo, m_lo);
    run_single(5'h14, 32'h0, 32'h0, 32'h1234);

    // Flush in IDLE suppresses acceptance.
    op = 5'h00; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_idle", out_valid, 0);

    // in_valid held high across ADD, MULT, ADD.
    op = 5'h00; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    tick();
    check_eq("b2b_add1", y, 32'd30);
    op = 5'h10; a = 32'hFFFF_FFFE; b = 32'd3;
    tick();
    op = 5'h00; a = 32'd7; b = 32'd8;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_eq("b2b_mult_lat", lat, W + 2);
    check_eq("b2b_mult_y", y, 32'hFFFF_FFFA);
    check_eq("b2b_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("b2b_add2_valid", out_valid, 1);
    check_eq("b2b_add2_y", y, 32'd15);
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFA;
    tick();
    check_eq("b2b_single_accept", out_valid, 0);
    $display("[%0t] b2b add/mult/add done", $time);

    // Reset in the middle of BUSY.
    op = 5'h10; a = 32'd5; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_hi", hi, 0);
    check_eq("midrst_lo", lo, 0);
    check_eq("midrst_ready", in_ready, 1);
    check_eq("midrst_valid", out_valid, 0);
    m_hi = '0;
    m_lo = '0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      tick();
    end
    check_eq("midrst_no_valid", seen, 0);
    $display("[%0t] reset mid-busy done", $time);

    // Randomized traffic.
    for (int i = 0; i < 160; i++) begin
      av = $urandom;
      bv = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        o = 5'h10 + 5'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
          0: bv = '0;
          1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
          2: bv = 32'($urandom_range(1, 9));
          default: ;
        endcase
        ref_muldiv(o, av, bv, ehi, elo);
        run_multi(o, av, bv, ehi, elo);
      end else begin
        o = 5'($urandom_range(0, 31));
        while (o >= 5'h10 && o <= 5'h13) o = 5'($urandom_range(0, 31));
        run_single(o, av, bv, ref_single(o, av, bv));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
